// File: rtl/wt_dcache_port_arb.sv
// Read-port arbiter in front of the write-through dcache array: two priority classes,
// round-robin within each class, and a starvation counter that forces a low-priority grant.
module wt_dcache_port_arb #(
    parameter int NumPorts    = 4,
    parameter int NumHiPrio   = 3,
    parameter int StarveLimit = 8,
    parameter int TagWidth    = 44,
    parameter int IdxWidth    = 8,
    parameter int OffWidth    = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    input  logic [NumPorts-1:0]               tag_only_i,
    input  logic [NumPorts-1:0][TagWidth-1:0] tag_i,
    input  logic [NumPorts-1:0][IdxWidth-1:0] idx_i,
    input  logic [NumPorts-1:0][OffWidth-1:0] off_i,
    output logic [NumPorts-1:0]               ack_o,
    output logic [NumPorts-1:0]               rsp_vld_o,
    input  logic                              wr_cl_vld_i,
    input  logic                              mem_rdy_i,
    output logic                              mem_req_o,
    output logic [TagWidth-1:0]               mem_tag_o,
    output logic [IdxWidth-1:0]               mem_idx_o,
    output logic [OffWidth-1:0]               mem_off_o,
    output logic                              mem_tag_only_o,
    output logic [$clog2(NumPorts)-1:0]       mem_port_o,
    output logic                              starve_o
);
    localparam int PortW = $clog2(NumPorts);

    logic [PortW-1:0]    hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d;
    logic [7:0]          starve_cnt_q, starve_cnt_d;
    logic [NumPorts-1:0] rsp_vld_q, ack_d;
    logic [PortW-1:0]    hi_sel, lo_sel, gnt_idx;
    logic                hi_found, lo_found, lo_pend, starving, grant_ok, use_lo;
    int                  hi_best, lo_best, hi_dist, lo_dist;

    // Per class, the requester closest above the pointer (modulo class size) wins.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        hi_best  = NumHiPrio;
        hi_dist  = 0;
        lo_found = 1'b0;
        lo_sel   = '0;
        lo_best  = NumPorts;
        lo_dist  = 0;
        for (int i = 0; i < NumHiPrio; i++) begin
            hi_dist = (i >= int'(hi_ptr_q)) ? i - int'(hi_ptr_q)
                                            : i + NumHiPrio - int'(hi_ptr_q);
            if (req_i[i] && hi_dist < hi_best) begin
                hi_best  = hi_dist;
                hi_sel   = PortW'(i);
                hi_found = 1'b1;
            end
        end
        for (int i = NumHiPrio; i < NumPorts; i++) begin
            lo_dist = (i >= int'(lo_ptr_q)) ? i - int'(lo_ptr_q)
                                            : i + (NumPorts - NumHiPrio) - int'(lo_ptr_q);
            if (req_i[i] && lo_dist < lo_best) begin
                lo_best  = lo_dist;
                lo_sel   = PortW'(i);
                lo_found = 1'b1;
            end
        end
    end

    assign lo_pend  = |req_i[NumPorts-1:NumHiPrio];
    assign starving = (starve_cnt_q == 8'(StarveLimit));
    assign grant_ok = ~rst_i & mem_rdy_i & ~wr_cl_vld_i & (|req_i);
    assign use_lo   = lo_found & (starving | ~hi_found);
    assign gnt_idx  = use_lo ? lo_sel : hi_sel;

    always_comb begin
        ack_d        = '0;
        hi_ptr_d     = hi_ptr_q;
        lo_ptr_d     = lo_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (grant_ok) begin
            ack_d[gnt_idx] = 1'b1;
            if (use_lo) begin
                lo_ptr_d = (lo_sel == PortW'(NumPorts - 1)) ? PortW'(NumHiPrio) : lo_sel + 1'b1;
            end else begin
                hi_ptr_d = (hi_sel == PortW'(NumHiPrio - 1)) ? '0 : hi_sel + 1'b1;
            end
        end
        // Blocked cycles still count towards starvation.
        if (grant_ok && use_lo) begin
            starve_cnt_d = '0;
        end else if (lo_pend && !starving) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_ptr_q     <= '0;
            lo_ptr_q     <= PortW'(NumHiPrio);
            starve_cnt_q <= '0;
            rsp_vld_q    <= '0;
        end else begin
            hi_ptr_q     <= hi_ptr_d;
            lo_ptr_q     <= lo_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_vld_q    <= ack_d;
        end
    end

    assign ack_o          = ack_d;
    assign rsp_vld_o      = rsp_vld_q;
    assign starve_o       = starving & ~rst_i;
    assign mem_req_o      = grant_ok;
    assign mem_tag_o      = grant_ok ? tag_i[gnt_idx] : '0;
    assign mem_idx_o      = grant_ok ? idx_i[gnt_idx] : '0;
    assign mem_off_o      = grant_ok ? off_i[gnt_idx] : '0;
    assign mem_tag_only_o = grant_ok & tag_only_i[gnt_idx];
    assign mem_port_o     = grant_ok ? gnt_idx : '0;

endmodule

// File: tb/tb_wt_dcache_port_arb.sv
// Bench for wt_dcache_port_arb: directed vector table, hand-written reset/mux sequences,
// randomized traffic against a class-search reference model, and an 8-port instance.
module tb_wt_dcache_port_arb;
    localparam int NP = 4, NH = 3, LIM = 8, TW = 44, IW = 8, OW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP-1:0]         req, tonly, ack, rsp;
    logic [NP-1:0][TW-1:0] tag;
    logic [NP-1:0][IW-1:0] idx;
    logic [NP-1:0][OW-1:0] off;
    logic                  wr, rdy, mreq, mtonly, starve;
    logic [TW-1:0]         mtag;
    logic [IW-1:0]         midx;
    logic [OW-1:0]         moff;
    logic [1:0]            mport;

    logic [7:0]         req8, tonly8, ack8, rsp8;
    logic [7:0][TW-1:0] tag8;
    logic [7:0][IW-1:0] idx8;
    logic [7:0][OW-1:0] off8;
    logic               wr8, rdy8, mreq8, mtonly8, starve8;
    logic [TW-1:0]      mtag8;
    logic [IW-1:0]      midx8;
    logic [OW-1:0]      moff8;
    logic [2:0]         mport8;

    wt_dcache_port_arb dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .tag_only_i(tonly), .tag_i(tag),
        .idx_i(idx), .off_i(off), .ack_o(ack), .rsp_vld_o(rsp), .wr_cl_vld_i(wr),
        .mem_rdy_i(rdy), .mem_req_o(mreq), .mem_tag_o(mtag), .mem_idx_o(midx),
        .mem_off_o(moff), .mem_tag_only_o(mtonly), .mem_port_o(mport), .starve_o(starve)
    );

    wt_dcache_port_arb #(.NumPorts(8), .NumHiPrio(4)) dut8 (
        .clk_i(clk), .rst_i(rst), .req_i(req8), .tag_only_i(tonly8), .tag_i(tag8),
        .idx_i(idx8), .off_i(off8), .ack_o(ack8), .rsp_vld_o(rsp8), .wr_cl_vld_i(wr8),
        .mem_rdy_i(rdy8), .mem_req_o(mreq8), .mem_tag_o(mtag8), .mem_idx_o(midx8),
        .mem_off_o(moff8), .mem_tag_only_o(mtonly8), .mem_port_o(mport8), .starve_o(starve8)
    );

    int n_chk = 0, n_fail = 0;

    // Reference model state: class pointers, starvation count, last grant vector.
    int            m_hi, m_lo, m_cnt;
    logic [NP-1:0] m_prev;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, a, e);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] r, input int base, input int size,
                                input int ptr);
        int p;
        for (int k = 0; k < size; k++) begin
            p = base + (ptr - base + k) % size;
            if (((r >> p) & 4'd1) != 4'd0) return p;
        end
        return -1;
    endfunction

    function automatic int model_grant();
        int h, l;
        if (!(rdy && !wr && req != '0)) return -1;
        h = pick(req, 0, NH, m_hi);
        l = pick(req, NH, NP - NH, m_lo);
        if (l >= 0 && (m_cnt == LIM || h < 0)) return l;
        return h;
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = NH; m_cnt = 0; m_prev = '0;
    endtask

    task automatic model_step();
        int g;
        g = model_grant();
        if (g >= 0 && g < NH) m_hi = (g + 1 == NH) ? 0 : g + 1;
        if (g >= NH) begin
            m_lo  = (g + 1 == NP) ? NH : g + 1;
            m_cnt = 0;
        end else if (req[NP-1:NH] != '0) begin
            m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
        end
        m_prev = (g >= 0) ? (4'd1 << g) : 4'd0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        int            g;
        logic [NP-1:0] e_ack;
        logic [1:0]    gi;
        g     = model_grant();
        e_ack = (g >= 0) ? (4'd1 << g) : 4'd0;
        gi    = 2'(g);
        chk($sformatf("rnd%0d ack", cyc), 64'(ack), 64'(e_ack));
        chk($sformatf("rnd%0d rsp", cyc), 64'(rsp), 64'(m_prev));
        chk($sformatf("rnd%0d starve", cyc), 64'(starve), 64'(m_cnt == LIM));
        chk($sformatf("rnd%0d mreq", cyc), 64'(mreq), 64'(g >= 0));
        chk($sformatf("rnd%0d mtag", cyc), 64'(mtag), (g >= 0) ? 64'(tag[gi]) : 64'd0);
        chk($sformatf("rnd%0d midx", cyc), 64'(midx), (g >= 0) ? 64'(idx[gi]) : 64'd0);
        chk($sformatf("rnd%0d moff", cyc), 64'(moff), (g >= 0) ? 64'(off[gi]) : 64'd0);
        chk($sformatf("rnd%0d mtonly", cyc), 64'(mtonly), (g >= 0) ? 64'(tonly[gi]) : 64'd0);
        chk($sformatf("rnd%0d mport", cyc), 64'(mport), (g >= 0) ? 64'(gi) : 64'd0);
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic       wr;
        logic       rdy;
        logic [3:0] ack;
        logic [3:0] rsp;
        logic       stv;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic w, input logic y,
                                input logic [3:0] a, input logic [3:0] s, input logic v);
        vec_t t;
        t.req = r; t.wr = w; t.rdy = y; t.ack = a; t.rsp = s; t.stv = v;
        return t;
    endfunction

    vec_t vecs[27];

    initial begin
        // hi round-robin, then a 3-cycle refill block
        vecs[0]  = mk(4'b0111, 0, 1, 4'b0001, 4'b0000, 0);
        vecs[1]  = mk(4'b0111, 0, 1, 4'b0010, 4'b0001, 0);
        vecs[2]  = mk(4'b0111, 0, 1, 4'b0100, 4'b0010, 0);
        vecs[3]  = mk(4'b0111, 0, 1, 4'b0001, 4'b0100, 0);
        vecs[4]  = mk(4'b0001, 1, 1, 4'b0000, 4'b0001, 0);
        vecs[5]  = mk(4'b0001, 1, 1, 4'b0000, 4'b0000, 0);
        vecs[6]  = mk(4'b0001, 1, 1, 4'b0000, 4'b0000, 0);
        vecs[7]  = mk(4'b0001, 0, 1, 4'b0001, 4'b0000, 0);
        // all four request: port 3 waits 8 cycles, then is forced through
        vecs[8]  = mk(4'b1111, 0, 1, 4'b0010, 4'b0001, 0);
        vecs[9]  = mk(4'b1111, 0, 1, 4'b0100, 4'b0010, 0);
        vecs[10] = mk(4'b1111, 0, 1, 4'b0001, 4'b0100, 0);
        vecs[11] = mk(4'b1111, 0, 1, 4'b0010, 4'b0001, 0);
        vecs[12] = mk(4'b1111, 0, 1, 4'b0100, 4'b0010, 0);
        vecs[13] = mk(4'b1111, 0, 1, 4'b0001, 4'b0100, 0);
        vecs[14] = mk(4'b1111, 0, 1, 4'b0010, 4'b0001, 0);
        vecs[15] = mk(4'b1111, 0, 1, 4'b0100, 4'b0010, 0);
        vecs[16] = mk(4'b1111, 0, 1, 4'b1000, 4'b0100, 1);
        vecs[17] = mk(4'b1111, 0, 1, 4'b0001, 4'b1000, 0);
        // mem not ready: starvation keeps counting while blocked
        vecs[18] = mk(4'b1000, 0, 0, 4'b0000, 4'b0001, 0);
        vecs[19] = mk(4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[20] = mk(4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[21] = mk(4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[22] = mk(4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[23] = mk(4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[24] = mk(4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[25] = mk(4'b1111, 0, 1, 4'b1000, 4'b0000, 1);
        vecs[26] = mk(4'b0000, 0, 1, 4'b0000, 4'b1000, 0);

        rst = 1'b1; req = 4'b1111; tonly = '0; wr = 1'b0; rdy = 1'b1;
        tag = '0; idx = '0; off = '0;
        req8 = '0; tonly8 = '0; wr8 = 1'b0; rdy8 = 1'b0; tag8 = '0; idx8 = '0; off8 = '0;
        tag[0] = 44'hABC; idx[0] = 8'h11;
        model_reset();
        #2;
        chk("rst ack", 64'(ack), 64'd0);
        chk("rst rsp", 64'(rsp), 64'd0);
        chk("rst mreq", 64'(mreq), 64'd0);
        chk("rst mtag", 64'(mtag), 64'd0);
        chk("rst midx", 64'(midx), 64'd0);
        chk("rst starve", 64'(starve), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; req = '0; tag = '0; idx = '0;
        #1;
        chk("post-rst idle ack", 64'(ack), 64'd0);
        chk("post-rst idle mreq", 64'(mreq), 64'd0);
        tick();

        for (int i = 0; i < 27; i++) begin
            req = vecs[i].req; wr = vecs[i].wr; rdy = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d ack", i), 64'(ack), 64'(vecs[i].ack));
            chk($sformatf("vec%0d rsp", i), 64'(rsp), 64'(vecs[i].rsp));
            chk($sformatf("vec%0d starve", i), 64'(starve), 64'(vecs[i].stv));
            chk($sformatf("vec%0d mreq", i), 64'(mreq), 64'(vecs[i].ack != 4'd0));
            tick();
        end

        // field mux on port 2 with a tag-only read
        tag[2] = 44'h123_4567_89AB; idx[2] = 8'h5A; off[2] = 4'h3; tonly = 4'b0100;
        req = 4'b0100; wr = 1'b0; rdy = 1'b1;
        #1;
        chk("mux ack", 64'(ack), 64'h4);
        chk("mux mtag", 64'(mtag), 64'h123_4567_89AB);
        chk("mux midx", 64'(midx), 64'h5A);
        chk("mux moff", 64'(moff), 64'h3);
        chk("mux mtonly", 64'(mtonly), 64'd1);
        chk("mux mport", 64'(mport), 64'd2);
        tick();
        req = '0; tonly = '0;
        #1;
        chk("mux rsp tag-only", 64'(rsp), 64'h4);
        chk("idle mtag zero", 64'(mtag), 64'd0);
        chk("idle midx zero", 64'(midx), 64'd0);
        tick();

        // reset one cycle after a grant to port 1
        req = 4'b0010;
        #1;
        chk("rstmid ack", 64'(ack), 64'h2);
        tick();
        req = 4'b0011;
        chk("rstmid rsp pre", 64'(rsp), 64'h2);
        rst = 1'b1;
        #1;
        chk("rstmid rsp", 64'(rsp), 64'd0);
        chk("rstmid ack", 64'(ack), 64'd0);
        chk("rstmid mreq", 64'(mreq), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = '0;
        model_reset();
        #1;
        chk("rstmid idle rsp", 64'(rsp), 64'd0);
        chk("rstmid idle ack", 64'(ack), 64'd0);
        tick();
        req = 4'b0011;
        #1;
        chk("rstmid first ack", 64'(ack), 64'h1);
        chk("rstmid first rsp", 64'(rsp), 64'd0);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            req   = 4'($urandom_range(0, 15));
            tonly = 4'($urandom_range(0, 15));
            wr    = ($urandom_range(0, 5) == 0);
            rdy   = ($urandom_range(0, 5) != 0);
            for (int p = 0; p < NP; p++) begin
                tag[p] = TW'({$urandom(), $urandom()});
                idx[p] = IW'($urandom());
                off[p] = OW'($urandom());
            end
            #1;
            check_model(c);
            tick();
        end
        req = '0;

        // 8-port instance: persistent low-only load cycles 4,5,6,7,4
        req8 = 8'hF0; rdy8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("p8 ack%0d", k), 64'(ack8), 64'd1 << (4 + k % 4));
            chk($sformatf("p8 port%0d", k), 64'(mport8), 64'(4 + k % 4));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wt_dcache_port_arb.md
WT_DCACHE_PORT_ARB -- requirements
Module: wt_dcache_port_arb

Interface
REQ-001 SHALL have parameter NumPorts, default 4: number of cache read requesters, 2..8.
REQ-002 SHALL have parameter NumHiPrio, default 3: ports 0..NumHiPrio-1 are high-priority; the remaining ports are low-priority; 1..NumPorts-1.
REQ-003 SHALL have parameter StarveLimit, default 8: low-priority wait cycles before a forced grant; 1..255.
REQ-004 SHALL have parameters TagWidth, default 44; IdxWidth, default 8; OffWidth, default 4.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_i, input, [NumPorts]: per-port read request.
REQ-008 SHALL have port tag_only_i, input, [NumPorts]: per-port tag-only read.
REQ-009 SHALL have port tag_i, input, [NumPorts][TagWidth]: per-port tag.
REQ-010 SHALL have port idx_i, input, [NumPorts][IdxWidth]: per-port index.
REQ-011 SHALL have port off_i, input, [NumPorts][OffWidth]: per-port offset.
REQ-012 SHALL have port ack_o, output, [NumPorts]: per-port grant.
REQ-013 SHALL have port rsp_vld_o, output, [NumPorts]: read data valid, one cycle after ack.
REQ-014 SHALL have port wr_cl_vld_i, input, 1 bit: cacheline refill/invalidate owns the array.
REQ-015 SHALL have port mem_rdy_i, input, 1 bit: array can accept a read this cycle.
REQ-016 SHALL have ports mem_req_o (1 bit), mem_tag_o, mem_idx_o, mem_off_o and mem_tag_only_o, outputs: the selected request.
REQ-017 SHALL have port mem_port_o, output, [$clog2(NumPorts)]: index of the selected port.
REQ-018 SHALL have port starve_o, output, 1 bit: a forced low-priority grant is in progress.

Function
REQ-019 SHALL define a grant as possible when mem_rdy_i=1, wr_cl_vld_i=0 and at least one req_i bit is set.
REQ-020 SHALL assert at most one ack_o bit per cycle, combinationally, in the grant cycle only.
REQ-021 SHALL, under normal selection, pick high-priority ports before low-priority ports.
REQ-022 SHALL arbitrate round-robin within each class, using separate pointers hi_ptr and lo_ptr.
REQ-023 SHALL search from its class pointer upward and wrap modulo the class size.
REQ-024 SHALL, on a grant, set the granted class's pointer to granted port+1, wrapping to the first port of that class; the other pointer is unchanged.
REQ-025 SHALL implement starve_cnt, 8 bit: increments each cycle any low-priority req is pending and no low-priority port is granted; clears on any low-priority grant; saturates at StarveLimit.
REQ-026 SHALL, when starve_cnt==StarveLimit, set starve_o=1 and give the next possible grant to the low-priority class regardless of high-priority requests.
REQ-027 SHALL drive mem_req_o=1 only in a grant cycle, with the mem_* fields taken from the granted port.
REQ-028 SHALL drive all mem_* data fields to 0 when mem_req_o=0.
REQ-029 SHALL register the grant vector and drive it on rsp_vld_o one cycle later; mem_tag_only_o does not suppress rsp_vld_o.
REQ-030 SHALL treat wr_cl_vld_i=1 as blocking all grants; starve_cnt keeps counting while blocked.
REQ-031 SHALL treat mem_rdy_i=0 the same as wr_cl_vld_i=1.
REQ-032 SHALL treat requests as level-based: a requester holds req_i and fields stable until ack; a dropped req is not remembered.
REQ-033 SHALL operate correctly if a port re-requests in the cycle after its ack; it is granted again only through normal round-robin order.
REQ-034 SHALL, with a single requester, grant every possible cycle, giving throughput 1/cycle.

Reset
REQ-035 SHALL, while rst_i=1, force ack_o=0, rsp_vld_o=0, mem_req_o=0, all mem_* fields=0 and starve_o=0 asynchronously.
REQ-036 SHALL, while rst_i=1, force hi_ptr=0, lo_ptr=NumHiPrio and starve_cnt=0.
REQ-037 SHALL make no grant in the first cycle after rst_i deasserts if req_i=0.
REQ-038 SHALL discard a pending response (rsp_vld_o) on reset mid-operation; no rsp_vld_o appears after reset release without a new grant.

Verification
REQ-039 SHALL be verified for hi round-robin (defaults): req_i=0111 held, mem_rdy_i=1 -> ack_o sequence 0001,0010,0100,0001; rsp_vld_o repeats it one cycle later.
REQ-040 SHALL be verified for starvation: req_i=1111 held -> port 3 waits 8 cycles; at starve_cnt=8, starve_o=1 and ack_o=1000; starve_cnt returns to 0.
REQ-041 SHALL be verified for refill block: req_i=0001, wr_cl_vld_i=1 for 3 cycles -> ack_o=0 and mem_req_o=0 for 3 cycles; ack_o=0001 in the cycle wr_cl_vld_i drops.
REQ-042 SHALL be verified for field mux: port 2 with idx=0x5A, off=0x3, tag_only=1 granted -> mem_idx_o=0x5A, mem_off_o=0x3, mem_tag_only_o=1, mem_port_o=2.
REQ-043 SHALL be verified for reset mid-op: grant to port 1, rst_i pulsed in the next cycle -> rsp_vld_o=0; after release hi_ptr=0, so req_i=0011 grants port 0 first.
REQ-044 SHALL be verified for a parameter sweep: NumPorts=8, NumHiPrio=4 -> lo round-robin 4,5,6,7,4 under a persistent low-only load.
